// File: rtl/mux_skid_n.sv
// mux_skid_n: selects one of NCH data channels or one of two constants,
// tags illegal selectors, and buffers the result in a two-entry skid
// buffer (head + skid) with valid/ready handshakes on both sides.
// in_ready is decoded from registered state only, so there is no
// combinational path from out_ready back to in_ready.
module mux_skid_n #(
    parameter int          WIDTH  = 32,
    parameter int          NCH    = 3,
    parameter int          SEL_W  = 3,
    parameter int unsigned CONST0 = 29,
    parameter int unsigned CONST1 = 31
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     sel,
    input  logic [NCH*WIDTH-1:0] data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_err,
    output logic [7:0]           err_count
);

    // Constants are zero-extended or truncated to the data path width.
    localparam logic [WIDTH-1:0] CONST0_VAL = WIDTH'(CONST0);
    localparam logic [WIDTH-1:0] CONST1_VAL = WIDTH'(CONST1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] head_data_reg;
    logic             head_err_reg;
    logic [WIDTH-1:0] skid_data_reg;
    logic             skid_err_reg;
    logic [7:0]       err_count_reg;

    logic             accept;
    logic             pop;
    logic             head_load_in;
    logic             head_load_skid;
    logic             skid_load_in;

    logic [WIDTH-1:0] chan [NCH];
    logic [NCH-1:0]   chan_hit;
    logic             const0_hit;
    logic             const1_hit;
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;

    // Unpack the flattened channel bus and decode one-hot channel hits.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            assign chan[gi]     = data_in[gi*WIDTH +: WIDTH];
            assign chan_hit[gi] = (int'(sel) == gi);
        end
    endgenerate

    assign const0_hit = (int'(sel) == NCH);
    assign const1_hit = (int'(sel) == NCH + 1);

    // Selector decode: channel, constant, or channel 0 flagged as an error.
    always_comb begin
        sel_data = chan[0];
        sel_err  = 1'b0;
        if (const0_hit) begin
            sel_data = CONST0_VAL;
        end else if (const1_hit) begin
            sel_data = CONST1_VAL;
        end else if (|chan_hit) begin
            for (int k = 0; k < NCH; k++) begin
                if (chan_hit[k]) begin
                    sel_data = chan[k];
                end
            end
        end else begin
            sel_err = 1'b1;
        end
    end

    // Handshake decode from registered state.
    assign in_ready  = (state_reg != FULL);
    assign out_valid = (state_reg != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and storage-control decode.
    always_comb begin
        state_next     = state_reg;
        head_load_in   = 1'b0;
        head_load_skid = 1'b0;
        skid_load_in   = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    state_next   = ONE;
                    head_load_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    state_next   = FULL;
                    skid_load_in = 1'b1;
                end else if (accept && pop) begin
                    // Head leaves and is replaced in the same cycle.
                    head_load_in = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_next     = ONE;
                    head_load_skid = 1'b1;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Head and skid storage; selection is captured only at the accepting edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_data_reg <= '0;
            head_err_reg  <= 1'b0;
            skid_data_reg <= '0;
            skid_err_reg  <= 1'b0;
        end else begin
            if (head_load_in) begin
                head_data_reg <= sel_data;
                head_err_reg  <= sel_err;
            end else if (head_load_skid) begin
                head_data_reg <= skid_data_reg;
                head_err_reg  <= skid_err_reg;
            end
            if (skid_load_in) begin
                skid_data_reg <= sel_data;
                skid_err_reg  <= sel_err;
            end
        end
    end

    // Saturating count of accepted illegal selectors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count_reg <= 8'd0;
        end else if (accept && sel_err && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign out_data  = head_data_reg;
    assign out_err   = head_err_reg;
    assign err_count = err_count_reg;

endmodule
